// File: rtl/serial_parallel_chunk_streamer_16_outputs.sv
// Frame buffer that fills one element per cycle, then streams 16-lane chunks.
// Define SERIAL_PARALLEL_STREAMER_MIN_PAD_EN to pad with the most negative value.
module serial_parallel_chunk_streamer_16_outputs #(
    parameter int WIDTH       = 8,
    parameter int INDEX_WIDTH = 8,
    parameter int MAX_CHUNKS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0][WIDTH-1:0] out,
    output logic [15:0]            out_lane_mask,
    output logic [INDEX_WIDTH-1:0] out_base,
    output logic                   out_first,
    output logic                   out_last
);

    localparam int DEPTH = 16 * MAX_CHUNKS;
    localparam int AW    = $clog2(DEPTH);
    localparam int NW    = $clog2(DEPTH + 1);
    localparam int CW    = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;

`ifdef SERIAL_PARALLEL_STREAMER_MIN_PAD_EN
    localparam logic [WIDTH-1:0] PAD = {1'b1, {(WIDTH-1){1'b0}}};
`else
    localparam logic [WIDTH-1:0] PAD = '0;
`endif

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [NW-1:0]    n_q, n_d;
    logic [CW-1:0]    chunk_q, chunk_d;
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic             wr_fire;
    logic             clr;
    logic             final_chunk;
    int               base;

    assign wr_ready    = (state_q == FILL);
    assign out_valid   = (state_q == STREAM);
    assign final_chunk = (int'(chunk_q) == (int'(n_q) + 15) / 16 - 1);

    // State, element count and chunk index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            n_q     <= '0;
            chunk_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            chunk_q <= chunk_d;
        end
    end

    // Next-state: accept elements in FILL, step chunks on handshake in STREAM
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        chunk_d = chunk_q;
        clr     = 1'b0;
        wr_fire = (state_q == FILL) && wr_valid;
        unique case (state_q)
            FILL: begin
                if (wr_fire) begin
                    n_d = n_q + NW'(1);
                    if (wr_last || (n_q == NW'(DEPTH - 1))) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (final_chunk) begin
                        state_d = FILL;
                        n_d     = '0;
                        chunk_d = '0;
                        clr     = 1'b1;
                    end else begin
                        chunk_d = chunk_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Element storage; refilled with pad after reset and after each frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= PAD;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= PAD;
            end
        end else if (wr_fire) begin
            buf_q[n_q[AW-1:0]] <= wr_data;
        end
    end

    // Chunk view of the buffer; all zero while filling
    always_comb begin
        out           = '0;
        out_lane_mask = '0;
        out_base      = '0;
        out_first     = 1'b0;
        out_last      = 1'b0;
        base          = int'(chunk_q) * 16;
        if (state_q == STREAM) begin
            for (int i = 0; i < 16; i++) begin
                out[i]           = buf_q[AW'(base + i)];
                out_lane_mask[i] = (base + i) < int'(n_q);
            end
            out_base  = INDEX_WIDTH'(base);
            out_first = (chunk_q == '0);
            out_last  = final_chunk;
        end
    end

endmodule
